// File: rtl/syn_fifo_pkg.sv
// syn_fifo_pkg: width helpers and parameter-legality check shared by the
// syn_fifo top and its storage array.
package syn_fifo_pkg;

  // Address width for a DEPTH-entry array; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must represent 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // True when the depth and threshold levels form a legal configuration.
  function automatic bit levels_ok(input int depth, input int af_level,
                                   input int ae_level);
    return (depth >= 2) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level >= 0) && (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/syn_fifo_mem.sv
// syn_fifo_mem: single-clock simple dual-port array with a registered read
// port. Only the read register is reset; the array itself is not.
module syn_fifo_mem
  import syn_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the word when enabled.
  // NOTE: storage arrays carry no reset so they map onto RAM primitives;
  // occupancy logic guarantees stale entries are never presented.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read port: registered output, cleared on reset, held when not reading.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/syn_fifo.sv
// syn_fifo: parametrised single-clock FIFO with arbitrary depth,
// almost-full/almost-empty thresholds, occupancy count and sticky
// overflow/underflow flags.
// Build option: define SYN_FIFO_FWFT_EN for first-word-fall-through output;
// otherwise rdata is a registered read with one cycle latency after rinc.
module syn_fifo
  import syn_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         winc,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         rinc,
  output logic [WIDTH-1:0]             rdata,
  output logic                         wfull,
  output logic                         rempty,
  output logic                         walmost_full,
  output logic                         ralmost_empty,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("syn_fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wen, ren, mem_re;

  // Status flags decode from registered state only, so they are glitch-free.
  assign wfull         = (count_q == CW'(DEPTH));
  assign walmost_full  = (count_q >= CW'(AF_LEVEL));
  assign ralmost_empty = (count_q <= CW'(AE_LEVEL));
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  assign wen = winc & ~wfull;
  assign ren = rinc & ~rempty;

`ifdef SYN_FIFO_FWFT_EN
  // The memory read register doubles as the output stage; stage_q marks
  // that it holds a live head word. count includes that word.
  logic          stage_q, stage_d;
  logic [CW-1:0] array_words;

  assign rempty      = ~stage_q;
  assign array_words = count_q - CW'(stage_q);
  // Fetch when the array has a word and the stage is empty or being popped.
  assign mem_re      = (array_words != '0) && (!stage_q || ren);

  // Next stage occupancy: refilled on fetch, drained on a pop without refill.
  always_comb begin
    stage_d = stage_q;
    if (mem_re)   stage_d = 1'b1;
    else if (ren) stage_d = 1'b0;
  end

  // Output stage valid register.
  always_ff @(posedge clk) begin
    if (rst) stage_q <= 1'b0;
    else     stage_q <= stage_d;
  end
`else
  assign rempty = (count_q == '0);
  assign mem_re = ren;
`endif

  // Next-state logic for pointers, occupancy and sticky error flags.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (winc & wfull);
    underflow_d = underflow_q | (rinc & rempty);
    if (wen)    wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
    if (mem_re) rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
    unique case ({wen, ren})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers; reset wins over any same-cycle request.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  syn_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wen),
    .waddr (wptr_q),
    .wdata (wdata),
    .re    (mem_re),
    .raddr (rptr_q),
    .rdata (rdata)
  );

endmodule

// File: doc/syn_fifo.md
Name: syn_fifo

Overview:
Parametrised single-clock FIFO; the next generation of the team's FIFO block for same-domain buffering.
Adds arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.
Sits between same-clock producer/consumer stages; storage is a registered-read single-clock dual-port array.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; any integer >=2, power of two not required
AF_LEVEL, DEPTH-2, walmost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, ralmost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous reset, active-high
winc  in  1  write request
wdata  in  WIDTH  write data
rinc  in  1  read request
rdata  out  WIDTH  read data
wfull  out  1  count == DEPTH
rempty  out  1  count == 0 (FWFT: no valid head word)
walmost_full  out  1  count >= AF_LEVEL
ralmost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Interface decided: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst high at posedge): wptr=0, rptr=0, count=0, rdata=0, overflow=0, underflow=0. Therefore rempty=1, wfull=0, ralmost_empty=1, and walmost_full=(AF_LEVEL==0)=0. Reset wins over any same-cycle winc/rinc. Mid-operation reset discards contents; array contents are not cleared.
- wen = winc & ~wfull; ren = rinc & ~rempty. Both are evaluated on pre-edge flags.
- Pointers are binary, $clog2(DEPTH) bits. A pointer at DEPTH-1 wraps to 0 on its enable; otherwise it increments by 1. No extra wrap bit is used; full/empty come from count.
- count next value: +1 if wen&~ren, -1 if ren&~wen, unchanged if both or neither.
- Simultaneous write and read when full: write is blocked (wfull), read proceeds, count becomes DEPTH-1, and overflow sets.
- Simultaneous write and read when empty: read is blocked, write proceeds, count becomes 1, and underflow sets.
- wfull, rempty, walmost_full and ralmost_empty are decoded from the count register only. They are glitch-free and update the cycle after the causing edge.
- Standard mode: on ren, rdata <= mem[rptr] at that edge, giving 1-cycle read latency. Otherwise rdata holds its value.
- Write-to-empty visibility: data written at edge N sets rempty=0 after edge N. A read issued at edge N+1 presents data after edge N+1.
- overflow sets on winc&wfull; underflow sets on rinc&rempty. Both clear only on rst.
- Writing when the FIFO is full does not modify the array.

Optional Feature:
- Macro: SYN_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - An output stage holds the head word. rdata is valid whenever rempty=0; rinc pops it.
  - A word written into an empty FIFO at edge N appears on rdata with rempty=0 after edge N+1 (2-cycle latency).
  - count includes the word in the output stage.
  - On a pop, the stage refills from the array in the same edge if a word is available; otherwise rempty=1.
  - rdata holds its last value while rempty=1.
- Undefined: standard registered-read behaviour as above.

Decomposition:
- Package syn_fifo_pkg: function for pointer width ($clog2 with minimum 1), function for count width, and a localparam-check helper that flags an illegal AF_LEVEL/AE_LEVEL range with $error at elaboration.
- Sub-module syn_fifo_mem: single-clock simple dual-port array with ports we, waddr, wdata, re, raddr, rdata; registered read; no reset on the array.

Test Plan (WIDTH=8, DEPTH=6, AF_LEVEL=4, AE_LEVEL=1):
- Reset then idle -> rempty=1, wfull=0, count=0, rdata=0x00, ralmost_empty=1, overflow=0, underflow=0.
- Write 0x11..0x16 on 6 consecutive cycles -> count 1..6; walmost_full rises after the 4th write; wfull=1 after the 6th. A 7th winc with 0x77 -> overflow=1, count stays 6.
- From full, read 6 times -> rdata 0x11..0x16 in order, each 1 cycle after rinc; rempty=1 after the last read. A further rinc -> underflow=1, rdata stays 0x16.
- Wrap-around: write 4, read 4, then write 0x21..0x26 and read all -> data order preserved across the pointer wrap 5->0, with no spurious full/empty.
- Simultaneous winc+rinc at count=3 for 10 cycles -> count stays 3 and output data order is correct. Same at count=6 -> write blocked, count=5, overflow=1. Same at count=0 -> count=1, underflow=1.
- Assert rst at count=4 with winc=rinc=1 -> next cycle count=0, rempty=1, sticky flags cleared. With SYN_FIFO_FWFT_EN, write 0xA5 into empty -> rdata=0xA5, rempty=0 two edges later without rinc.
